// File: rtl/systolic_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_collector
// Purpose  : Collects the bottom-edge outputs of a weight-stationary systolic
//            array and turns them into whole result rows. Column j of a vector
//            arrives j cycles after column 0, so each column is delayed by
//            N-1-j enabled cycles to line the row up. Aligned rows go into a
//            FIFO that drains on a valid/ready handshake. A credit output
//            tells the feeder when a new vector is guaranteed a FIFO slot.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            enable          - array enable; delay lines only move when 1
//            vec_valid       - feeder launches a vector this cycle
//            result_i        - packed column results, column j at [j*DATA_W +: DATA_W]
//            issue_ok        - feeder may launch a vector this cycle
//            row_valid/row_data/row_ready - FIFO head handshake
//            fifo_count      - buffered row count
//            overflow        - sticky flag: an aligned row was dropped
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_collector #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           vec_valid,
    input  logic [ARRAY_SIZE*DATA_W-1:0]   result_i,
    output logic                           issue_ok,
    output logic                           row_valid,
    output logic [ARRAY_SIZE*DATA_W-1:0]   row_data,
    input  logic                           row_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow
);

    localparam int c_ROW_W   = ARRAY_SIZE * DATA_W;
    localparam int c_VLD_LEN = 2 * ARRAY_SIZE - 1;
    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    // In-flight vectors never exceed the valid-pipeline length (2N-1).
    localparam int c_INF_W   = $clog2(2 * ARRAY_SIZE) + 1;

    // ------------------------------------------------------------------
    // De-skew delay lines: column j gets N-1-j enabled-only stages so
    // that every column of a vector lands in the same cycle.
    // ------------------------------------------------------------------
    logic [c_ROW_W-1:0] w_row;

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        if (j == ARRAY_SIZE - 1) begin : g_direct
            assign w_row[j*DATA_W +: DATA_W] = result_i[j*DATA_W +: DATA_W];
        end else begin : g_delay
            localparam int c_DEPTH = ARRAY_SIZE - 1 - j;
            logic [DATA_W-1:0] dly_q [c_DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < c_DEPTH; s++) begin
                        dly_q[s] <= '0;
                    end
                end else if (enable) begin
                    dly_q[0] <= result_i[j*DATA_W +: DATA_W];
                    for (int s = 1; s < c_DEPTH; s++) begin
                        dly_q[s] <= dly_q[s-1];
                    end
                end
            end

            assign w_row[j*DATA_W +: DATA_W] = dly_q[c_DEPTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Launch tracking: vec_valid ripples through 2N-1 enabled stages and
    // reaches the end exactly when the aligned row is on w_row.
    // ------------------------------------------------------------------
    logic [c_VLD_LEN-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (enable) begin
            vld_q[0] <= vec_valid;
            for (int i = 1; i < c_VLD_LEN; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    logic [c_ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_INF_W-1:0] inflight_q, inflight_d;
    logic               overflow_q, overflow_d;

    logic w_push_req;   // an aligned row is due this cycle
    logic w_push;       // the row is actually written
    logic w_pop;
    logic w_full;
    logic w_launch;
    logic [31:0] w_credit_used;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_push_req = enable && vld_q[c_VLD_LEN-1];
    assign w_full     = (count_q == c_CNT_W'(FIFO_DEPTH));
    assign w_pop      = (count_q != '0) && row_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_launch   = vec_valid && enable;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A dropped row still retires its in-flight slot.
        case ({w_launch, w_push_req})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (w_push_req && !w_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= w_row;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_credit_used = 32'(count_q) + 32'(inflight_q);
    assign issue_ok      = !reset && (w_credit_used < 32'(FIFO_DEPTH));
    assign row_valid     = (count_q != '0);
    assign row_data      = row_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

endmodule

`default_nettype wire

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
Sits at the bottom edge of the 16x16 weight-stationary systolic array and consumes its column results. It realigns the column outputs, which arrive skewed by one cycle per column, into whole result rows. Each row is buffered in a FIFO and presented downstream on a valid/ready handshake. It also gives the input feeder a credit signal so that no launched vector can ever lose its result row.

Parameters:
ARRAY_SIZE, 16, number of array columns (N).
DATA_W, 16, width of one column result.
FIFO_DEPTH, 32, number of buffered aligned rows; must be a power of two and at least 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  the same enable that drives the array; delay lines advance only when it is 1.
vec_valid  input  1  pulses in the cycle the feeder presents row 0 of input vector k to the array.
result_i  input  N*DATA_W  array bottom-row outputs; column j at bits [j*DATA_W+DATA_W-1 : j*DATA_W].
issue_ok  output  1  feeder may assert vec_valid this cycle.
row_valid  output  1  FIFO head row is available.
row_data  output  N*DATA_W  FIFO head row, packed the same way as result_i.
row_ready  input  1  downstream accepts the row.
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset: FIFO empty, all delay registers and valid bits cleared, in-flight counter = 0, row_valid = 0, row_data = 0, fifo_count = 0, overflow = 0.
- Array timing contract, counted in enabled cycles: column j of vector k is valid on result_i at t_k + N + j, where t_k is the cycle in which vec_valid is asserted.
- De-skew:
  - Column j passes through N-1-j enabled-only registers, so column N-1 is used directly.
  - vec_valid passes through a 2N-1 stage valid shift register.
  - All stages shift only when enable = 1. When enable = 0 they hold, including any pending push.
- Push: when the last valid stage is 1 and enable = 1, the aligned row is written to the FIFO tail. This is 2N-1 = 31 enabled cycles after vec_valid.
- Pop: when row_valid && row_ready, the head advances. Pop is independent of enable.
- FIFO boundary cases:
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push while full with no pop: the row is dropped and overflow is set; it stays 1 until reset.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- In-flight counter:
  - Increments on vec_valid && enable and decrements on push. Both in the same cycle leaves it unchanged.
  - A dropped push still decrements it.
- Credit: issue_ok = !reset && (fifo_count + inflight < FIFO_DEPTH). This is combinational from registered state.
  - vec_valid asserted while issue_ok = 0 is not rejected; the vector is tracked.
  - The resulting possible drop is flagged through overflow.
- vec_valid && enable = 0: not launched, ignored.
- row_valid = (fifo_count != 0). row_data shows the head entry and holds stable while row_valid && !row_ready.
- Reset mid-operation discards all in-flight and buffered rows. result_i values of vectors launched before reset are never pushed.
- Latency with an empty FIFO: row_valid rises the cycle after the push, i.e. 2N = 32 cycles after vec_valid.

Test Plan:
- Single vector: reset, then vec_valid at cycle 0 with enable = 1. Bench drives column j = {8'h00, j[7:0]} at cycle 16+j, 0 elsewhere. Required: row_valid at cycle 32, row_data column j = j, fifo_count = 1; after row_ready, row_valid = 0.
- Streaming: 32 back-to-back vectors, column j of vector k = {k[7:0], j[7:0]}, row_ready = 1. Required: issue_ok stays 1, rows emerge in cycles 32..63 in order k = 0..31, overflow = 0.
- Backpressure: row_ready = 0 and launch while issue_ok = 1. Required: issue_ok falls after 32 launches, fifo_count reaches 32 after all pushes, overflow = 0. Draining one row raises issue_ok.
- Enable freeze: launch vector 0, then deassert enable for 5 cycles at cycle 10. Required: row_valid at cycle 37, data intact.
- Overflow: force vec_valid while issue_ok = 0 with ready held low. Required: 33rd push is dropped, overflow = 1 and sticky, fifo_count = 32; the bench confirms the FIFO contents match rows 0..31.
- Reset mid-stream: reset at cycle 20 after 5 launches. Required: all outputs 0 the next cycle, no row_valid afterwards, issue_ok = 1.
